// File: rtl/seg_pkg.sv
// seg_pkg: active-low segment constants, scroll states and circular index helper
package seg_pkg;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] DP_MASK = 8'h7F;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int wrap_idx(input int s, input int n);
    return (s >= n) ? s - n : s;
  endfunction
endpackage

// File: rtl/seg_tick_gen.sv
// seg_tick_gen: one-cycle enable every DIV cycles while en, restartable via clr
module seg_tick_gen #(
  parameter int DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  logic [CW-1:0] cnt;
  assign tick = en && (cnt == LAST);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + CW'(1);
endmodule

// File: rtl/seg_scroll_buffer.sv
// seg_scroll_buffer: message buffer with a scrolling 4-digit window for the scan driver.
// SEG_SCROLL_BOUNCE_EN selects ping-pong scrolling instead of circular.
module seg_scroll_buffer import seg_pkg::*; #(
  parameter int MSG_LEN = 8,
  parameter int SCROLL_DIV = 50_000_000,
  localparam int AW = $clog2(MSG_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          start,
  input  logic          stop,
  input  logic          clear,
  output logic          busy,
  output logic [7:0]    digit3,
  output logic [7:0]    digit2,
  output logic [7:0]    digit1,
  output logic [7:0]    digit0,
  output logic          wrap_pulse
);
  state_t state, state_d;
  logic [AW-1:0] offset, offset_d;
  logic [7:0] msg [MSG_LEN];
  logic [AW-1:0] idx [4];
  logic [7:0] win [4];
  logic tick, step, start_acc, wrap_d, wr_ok;
  assign start_acc = start && !stop && !clear && state == IDLE;
  assign busy = state == RUN;
  assign step = tick && !clear;
  assign wr_ok = wr_en && int'(wr_addr) < MSG_LEN;
  always_comb state_d = clear ? state : stop ? IDLE : start_acc ? RUN : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;
  seg_tick_gen #(.DIV(SCROLL_DIV)) u_tick (
    .clk(clk), .rst(rst), .clr(clear || start_acc), .en(state == RUN), .tick(tick)
  );
`ifdef SEG_SCROLL_BOUNCE_EN
  localparam logic [AW-1:0] TOP = AW'(MSG_LEN - 4);
  logic dir, dir_d;
  // dir = 1 walks backward; reversal happens on the step that leaves an end
  always_comb begin
    wrap_d = dir ? (offset == '0) : (offset == TOP);
    dir_d = dir ^ wrap_d;
    offset_d = (MSG_LEN == 4) ? '0 : dir_d ? offset - AW'(1) : offset + AW'(1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) dir <= 1'b0;
    else if (clear) dir <= 1'b0;
    else if (step) dir <= dir_d;
`else
  always_comb begin
    wrap_d = offset == AW'(MSG_LEN - 1);
    offset_d = wrap_d ? '0 : offset + AW'(1);
  end
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      offset <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= step && wrap_d;
      if (clear) offset <= '0;
      else if (step) offset <= offset_d;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < MSG_LEN; i++) msg[i] <= SEG_BLANK;
    else if (wr_ok) msg[wr_addr] <= wr_data;
  // forward a same-cycle write so it reaches its digit one cycle after the write
  always_comb
    for (int k = 0; k < 4; k++) begin
      idx[k] = AW'(wrap_idx(int'(offset) + k, MSG_LEN));
      win[k] = (wr_ok && wr_addr == idx[k]) ? wr_data : msg[idx[k]];
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      digit3 <= SEG_BLANK;
      digit2 <= SEG_BLANK;
      digit1 <= SEG_BLANK;
      digit0 <= SEG_BLANK;
    end else begin
      digit3 <= win[0];
      digit2 <= win[1];
      digit1 <= win[2];
      digit0 <= win[3];
    end
endmodule
